stim_burst_scheduler: RTL and testbench
=======================================

STIM_BURST_SCHEDULER -- requirements
Module: stim_burst_scheduler

Interface
REQ-001 SHALL have ports: clk  input  1  system clock, 20 kHz.
REQ-002 SHALL have ports: reset_l  input  1  reset, asynchronous, active-low.
REQ-003 SHALL have ports: enable  input  1  stimulation enable from conf1[20].
REQ-004 SHALL have ports: amplitude  input  6  target amplitude code, in mA.
REQ-005 SHALL have ports: freq  input  12  pulse period, in clk cycles.
REQ-006 SHALL have ports: phase_dur  input  3  phase width, in clk cycles.
REQ-007 SHALL have ports: ramp_factor  input  10  ramp step per pulse, in 1/16 amplitude units.
REQ-008 SHALL have ports: on_time  input  8  pulses per ON burst.
REQ-009 SHALL have ports: off_time  input  10  silent periods per OFF interval.
REQ-010 SHALL have ports: electrode1 / electrode2  input  `ELEC_NUM+1  anode / cathode electrode selects.
REQ-011 SHALL have ports: up_switches / down_switches  output  `ELEC_NUM+1  H-bridge P / N switch enables.
REQ-012 SHALL have ports: DAC  output  6  current amplitude code; pulse_active  output  1  pulse in progress.

Function
REQ-013 SHALL implement states IDLE, WAIT, PHASE_A, GAP, PHASE_B, OFF; all outputs SHALL be registered.
REQ-014 IDLE: leave only when enable=1, freq!=0 and on_time!=0; next edge -> PHASE_A (first pulse), ramp accumulator cleared.
REQ-015 SHALL shadow-latch amplitude, freq, phase_dur, ramp_factor, on_time, off_time and electrodes on entry to each ON burst; mid-burst input changes SHALL take effect at the next burst only.
REQ-016 PHASE_A: up=electrode1, down=electrode2, DAC=current amplitude, for max(phase_dur,1) cycles.
REQ-017 GAP: exactly 1 cycle, switches all 0, DAC=0, pulse_active=1.
REQ-018 PHASE_B: up=electrode2, down=electrode1, DAC unchanged from PHASE_A, for max(phase_dur,1) cycles.
REQ-019 pulse_active SHALL be 1 in PHASE_A/GAP/PHASE_B only; outside these, switches and DAC SHALL be 0.
REQ-020 Pulse starts SHALL be spaced freq cycles apart; if 2*phase+1 >= freq, the next PHASE_A SHALL begin on the cycle after PHASE_B ends.
REQ-021 Ramp: 11-bit accumulator, incremented by ramp_factor before each pulse and saturated at amplitude*16; DAC = acc[9:4]; ramp_factor=0 SHALL give DAC=amplitude from the first pulse.
REQ-022 After on_time pulses -> OFF for off_time*freq cycles, then -> new burst (re-latch, ramp restart); off_time=0 SHALL restart immediately at the next period slot.
REQ-023 enable=0 in WAIT/OFF -> IDLE next edge; in PHASE_A/GAP/PHASE_B the pulse SHALL complete PHASE_B (charge balance) then -> IDLE.
REQ-024 Counters SHALL never wrap; all widths SHALL be sized for the maximum field values (period 4095, OFF 1023*4095 cycles).

Reset
REQ-025 reset_l=0 SHALL asynchronously force IDLE, all counters and the accumulator to 0, and up/down_switches=0, DAC=0, pulse_active=0, including mid-pulse.
REQ-026 After release, SHALL wait for enable per REQ-014; no pulse SHALL be resumed.

Structure
REQ-027 State encoding, GAP length and the ELEC_NUM width SHALL live in the shared defines/package used by aska_dig.
REQ-028 The biphasic phase sequencing (PHASE_A/GAP/PHASE_B timing and switch mapping) SHALL be a sub-module stim_pulse_gen; burst/ramp/period scheduling stays in the top.

Verification (amplitude=50, freq=400, phase=4, ramp_factor=16, on=50, off=50, ele1=bit15, ele2=bit14)
REQ-029 Enable rise -> PHASE_A next edge: up=0x8000, down=0x4000 for 4 cycles, 1-cycle gap, reversed 4 cycles; DAC=1,2,...; pulse n DAC=n, held at 50 from pulse 50; starts 400 cycles apart.
REQ-030 After pulse 50 -> silence for 20000 cycles; next burst first pulse has DAC=1.
REQ-031 enable dropped in cycle 2 of PHASE_A -> pulse completes both phases, then IDLE with all outputs 0; re-enable restarts at DAC=1.
REQ-032 reset_l low mid-PHASE_B -> outputs 0 before the next clk edge; no pulse after release until enable is seen.
REQ-033 ramp_factor=0, freq=5 -> DAC=50 on every pulse; pulse starts 9 cycles apart.
REQ-034 amplitude changed to 20 mid-burst -> current burst ramps to 50; next burst saturates at 20.

Source files
------------

// File: rtl/stim_burst_scheduler_pkg.sv
// Shared types and constants for the stimulation burst scheduler.
package stim_burst_scheduler_pkg;

  // Highest electrode index; select and switch buses are ElecNum+1 bits wide.
  localparam int unsigned ElecNum = 15;
  localparam int unsigned ElecW   = ElecNum + 1;

  // Inter-phase gap length in clk cycles, and its down-counter load value.
  localparam int unsigned GapCycles = 1;
  localparam logic [2:0]  GapLoad   = 3'(GapCycles - 1);

  // Stimulator state encoding. The scheduler uses StIdle/StWait/StOff, the
  // pulse generator uses StIdle/StPhaseA/StGap/StPhaseB.
  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StWait   = 3'd1,
    StPhaseA = 3'd2,
    StGap    = 3'd3,
    StPhaseB = 3'd4,
    StOff    = 3'd5
  } stim_state_e;

  // One ramp step: add ramp to the accumulator, saturating at amp*16.
  // A zero ramp jumps straight to full amplitude.
  function automatic logic [10:0] ramp_step(input logic [10:0] acc,
                                            input logic [9:0]  ramp,
                                            input logic [5:0]  amp);
    logic [10:0] cap;
    logic [11:0] sum;
    cap = {1'b0, amp, 4'b0000};
    sum = {1'b0, acc} + {2'b00, ramp};
    if ((ramp == 10'd0) || (sum >= {1'b0, cap})) begin
      return cap;
    end
    return sum[10:0];
  endfunction

endpackage

// File: rtl/stim_burst_scheduler_pulse_gen.sv
// Biphasic pulse sequencer: PHASE_A, fixed gap, PHASE_B with swapped switches.
// All outputs are registered; a start on the last PHASE_B cycle chains pulses.
module stim_pulse_gen
  import stim_burst_scheduler_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic [2:0]       phase_dur_i,
  input  logic [5:0]       dac_i,
  input  logic [ElecW-1:0] elec_a_i,
  input  logic [ElecW-1:0] elec_b_i,
  output stim_state_e      state_o,
  output logic             last_o,
  output logic [ElecW-1:0] up_o,
  output logic [ElecW-1:0] down_o,
  output logic [5:0]       dac_o,
  output logic             active_o
);

  stim_state_e      state_q;
  logic [2:0]       cnt_q;
  logic [2:0]       ph_q;
  logic [5:0]       dac_q;
  logic [ElecW-1:0] elec_a_q;
  logic [ElecW-1:0] elec_b_q;
  logic [2:0]       ph_ld;
  logic             load;

  // Phase length load value (zero width behaves as one cycle) and start qualification.
  always_comb begin
    ph_ld  = (phase_dur_i == 3'd0) ? 3'd0 : phase_dur_i - 3'd1;
    last_o = (state_q == StPhaseB) && (cnt_q == 3'd0);
    load   = start_i && ((state_q == StIdle) || last_o);
  end

  assign state_o = state_q;

  // Phase sequencer with registered switch, DAC and activity outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= StIdle;
      cnt_q    <= '0;
      ph_q     <= '0;
      dac_q    <= '0;
      elec_a_q <= '0;
      elec_b_q <= '0;
      up_o     <= '0;
      down_o   <= '0;
      dac_o    <= '0;
      active_o <= 1'b0;
    end else if (load) begin
      state_q  <= StPhaseA;
      cnt_q    <= ph_ld;
      ph_q     <= ph_ld;
      dac_q    <= dac_i;
      elec_a_q <= elec_a_i;
      elec_b_q <= elec_b_i;
      up_o     <= elec_a_i;
      down_o   <= elec_b_i;
      dac_o    <= dac_i;
      active_o <= 1'b1;
    end else begin
      unique case (state_q)
        StPhaseA: begin
          if (cnt_q == 3'd0) begin
            state_q <= StGap;
            cnt_q   <= GapLoad;
            up_o    <= '0;
            down_o  <= '0;
            dac_o   <= '0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StGap: begin
          if (cnt_q == 3'd0) begin
            state_q <= StPhaseB;
            cnt_q   <= ph_q;
            up_o    <= elec_b_q;
            down_o  <= elec_a_q;
            dac_o   <= dac_q;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        StPhaseB: begin
          if (cnt_q == 3'd0) begin
            state_q  <= StIdle;
            up_o     <= '0;
            down_o   <= '0;
            dac_o    <= '0;
            active_o <= 1'b0;
          end else begin
            cnt_q <= cnt_q - 3'd1;
          end
        end
        default: begin
          state_q  <= StIdle;
          up_o     <= '0;
          down_o   <= '0;
          dac_o    <= '0;
          active_o <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/stim_burst_scheduler.sv
// Burst scheduler: period spacing, ON/OFF bursts, amplitude ramp and shadow
// registers. Biphasic sequencing is delegated to stim_pulse_gen.
module stim_burst_scheduler
  import stim_burst_scheduler_pkg::*;
(
  input  logic             clk,
  input  logic             reset_l,
  input  logic             enable,
  input  logic [5:0]       amplitude,
  input  logic [11:0]      freq,
  input  logic [2:0]       phase_dur,
  input  logic [9:0]       ramp_factor,
  input  logic [7:0]       on_time,
  input  logic [9:0]       off_time,
  input  logic [ElecW-1:0] electrode1,
  input  logic [ElecW-1:0] electrode2,
  output logic [ElecW-1:0] up_switches,
  output logic [ElecW-1:0] down_switches,
  output logic [5:0]       DAC,
  output logic             pulse_active
);

  stim_state_e      state_q;
  logic [5:0]       amp_q;
  logic [11:0]      freq_q;
  logic [2:0]       phase_q;
  logic [9:0]       ramp_q;
  logic [7:0]       on_q;
  logic [9:0]       off_q;
  logic [ElecW-1:0] e1_q;
  logic [ElecW-1:0] e2_q;
  logic [10:0]      acc_q;
  logic [7:0]       pulses_q;
  logic [11:0]      slot_q;    // cycles since pulse start (WAIT) or within OFF period
  logic [9:0]       offp_q;    // completed OFF periods

  stim_state_e      pg_state;
  logic             pg_last;
  logic             pg_free;
  logic             burst_ok;
  logic             slot_due;
  logic             new_burst;
  logic             next_pulse;
  logic             go_idle;
  logic             go_off;
  logic             pulse_start;
  logic [10:0]      acc_new;
  logic [2:0]       pulse_phase;
  logic [ElecW-1:0] pulse_e1;
  logic [ElecW-1:0] pulse_e2;

  // Scheduling decisions; a new burst takes its parameters from the live inputs.
  always_comb begin
    burst_ok   = enable && (freq != 12'd0) && (on_time != 8'd0);
    pg_free    = (pg_state == StIdle) || pg_last;
    // Long pulses push the next start to the cycle after PHASE_B ends.
    slot_due   = (slot_q >= freq_q - 12'd1) && pg_free;
    new_burst  = 1'b0;
    next_pulse = 1'b0;
    go_idle    = 1'b0;
    go_off     = 1'b0;
    unique case (state_q)
      StIdle: new_burst = burst_ok;
      StWait: begin
        if (!enable) begin
          // Never cut a pulse short: wait for PHASE_B to finish.
          go_idle = pg_free;
        end else if (slot_due) begin
          if (pulses_q < on_q) begin
            next_pulse = 1'b1;
          end else if (off_q != 10'd0) begin
            go_off = 1'b1;
          end else if (burst_ok) begin
            new_burst = 1'b1;
          end else begin
            go_idle = 1'b1;
          end
        end
      end
      StOff: begin
        if (!enable) begin
          go_idle = 1'b1;
        end else if ((slot_q == freq_q - 12'd1) && (offp_q == off_q - 10'd1)) begin
          new_burst = burst_ok;
          go_idle   = !burst_ok;
        end
      end
      default: go_idle = 1'b1;
    endcase

    acc_new     = new_burst ? ramp_step(11'd0, ramp_factor, amplitude)
                            : ramp_step(acc_q, ramp_q, amp_q);
    pulse_phase = new_burst ? phase_dur  : phase_q;
    pulse_e1    = new_burst ? electrode1 : e1_q;
    pulse_e2    = new_burst ? electrode2 : e2_q;
    pulse_start = new_burst || next_pulse;
  end

  // Scheduler state, shadow registers, ramp accumulator and counters.
  always_ff @(posedge clk or negedge reset_l) begin
    if (!reset_l) begin
      state_q  <= StIdle;
      amp_q    <= '0;
      freq_q   <= '0;
      phase_q  <= '0;
      ramp_q   <= '0;
      on_q     <= '0;
      off_q    <= '0;
      e1_q     <= '0;
      e2_q     <= '0;
      acc_q    <= '0;
      pulses_q <= '0;
      slot_q   <= '0;
      offp_q   <= '0;
    end else if (new_burst) begin
      state_q  <= StWait;
      amp_q    <= amplitude;
      freq_q   <= freq;
      phase_q  <= phase_dur;
      ramp_q   <= ramp_factor;
      on_q     <= on_time;
      off_q    <= off_time;
      e1_q     <= electrode1;
      e2_q     <= electrode2;
      acc_q    <= acc_new;
      pulses_q <= 8'd1;
      slot_q   <= '0;
      offp_q   <= '0;
    end else if (next_pulse) begin
      acc_q    <= acc_new;
      pulses_q <= pulses_q + 8'd1;
      slot_q   <= '0;
    end else if (go_idle) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      pulses_q <= '0;
      slot_q   <= '0;
      offp_q   <= '0;
    end else if (go_off) begin
      state_q <= StOff;
      slot_q  <= '0;
      offp_q  <= '0;
    end else if (state_q == StOff) begin
      if (slot_q == freq_q - 12'd1) begin
        slot_q <= '0;
        if (offp_q != 10'h3ff) offp_q <= offp_q + 10'd1;
      end else begin
        slot_q <= slot_q + 12'd1;
      end
    end else if ((state_q == StWait) && (slot_q != 12'hfff)) begin
      slot_q <= slot_q + 12'd1;
    end
  end

  stim_pulse_gen u_pulse_gen (
    .clk_i       (clk),
    .rst_ni      (reset_l),
    .start_i     (pulse_start),
    .phase_dur_i (pulse_phase),
    .dac_i       (acc_new[9:4]),
    .elec_a_i    (pulse_e1),
    .elec_b_i    (pulse_e2),
    .state_o     (pg_state),
    .last_o      (pg_last),
    .up_o        (up_switches),
    .down_o      (down_switches),
    .dac_o       (DAC),
    .active_o    (pulse_active)
  );

endmodule

// File: tb/tb_stim_burst_scheduler.sv
// Directed bench for stim_burst_scheduler: cycle-by-cycle comparison of
// {up_switches, down_switches, DAC, pulse_active} against hand-derived values.
module tb_stim_burst_scheduler;

  localparam logic [15:0] E1 = 16'h8000;
  localparam logic [15:0] E2 = 16'h4000;

  logic        clk;
  logic        reset_l;
  logic        enable;
  logic [5:0]  amplitude;
  logic [11:0] freq;
  logic [2:0]  phase_dur;
  logic [9:0]  ramp_factor;
  logic [7:0]  on_time;
  logic [9:0]  off_time;
  logic [15:0] electrode1;
  logic [15:0] electrode2;
  logic [15:0] up_switches;
  logic [15:0] down_switches;
  logic [5:0]  DAC;
  logic        pulse_active;
  logic [38:0] obs;

  int n_vec;
  int n_err;
  int model_acc;

  stim_burst_scheduler dut (
    .clk           (clk),
    .reset_l       (reset_l),
    .enable        (enable),
    .amplitude     (amplitude),
    .freq          (freq),
    .phase_dur     (phase_dur),
    .ramp_factor   (ramp_factor),
    .on_time       (on_time),
    .off_time      (off_time),
    .electrode1    (electrode1),
    .electrode2    (electrode2),
    .up_switches   (up_switches),
    .down_switches (down_switches),
    .DAC           (DAC),
    .pulse_active  (pulse_active)
  );

  assign obs = {up_switches, down_switches, DAC, pulse_active};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [38:0] got, input logic [38:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got up=%h dn=%h dac=%0d act=%b, want up=%h dn=%h dac=%0d act=%b",
               tag, got[38:23], got[22:7], got[6:1], got[0],
               exp[38:23], exp[22:7], exp[6:1], exp[0]);
    end
  endtask

  // Expected outputs at cycle k of a pulse (k=0 is the first PHASE_A cycle).
  function automatic logic [38:0] exp_out(input int k, input int ph, input int dac);
    int         p;
    logic [5:0] d;
    p = (ph == 0) ? 1 : ph;
    d = 6'(dac);
    if (k < p) return {E1, E2, d, 1'b1};
    if (k == p) return {16'h0, 16'h0, 6'h0, 1'b1};
    if (k < 2 * p + 1) return {E2, E1, d, 1'b1};
    return 39'h0;
  endfunction

  // Check n whole pulse slots; entered on the first PHASE_A cycle of the first one.
  task automatic run_burst(input string tag, input int fq, input int ph, input int rmp,
                           input int amp, input int n);
    int p;
    int per;
    int dac;
    p   = (ph == 0) ? 1 : ph;
    per = (fq > 2 * p + 1) ? fq : 2 * p + 1;
    for (int i = 0; i < n; i++) begin
      if (rmp == 0) begin
        model_acc = amp * 16;
      end else begin
        model_acc = model_acc + rmp;
        if (model_acc > amp * 16) model_acc = amp * 16;
      end
      dac = model_acc / 16;
      for (int k = 0; k < per; k++) begin
        check_eq($sformatf("%s p%0d c%0d", tag, i + 1, k), obs, exp_out(k, ph, dac));
        @(negedge clk);
      end
    end
  endtask

  task automatic quiet(input string tag, input int n);
    for (int k = 0; k < n; k++) begin
      check_eq($sformatf("%s c%0d", tag, k), obs, 39'h0);
      @(negedge clk);
    end
  endtask

  initial begin
    n_vec       = 0;
    n_err       = 0;
    model_acc   = 0;
    reset_l     = 1'b0;
    enable      = 1'b0;
    amplitude   = 6'd50;
    freq        = 12'd400;
    phase_dur   = 3'd4;
    ramp_factor = 10'd16;
    on_time     = 8'd50;
    off_time    = 10'd50;
    electrode1  = E1;
    electrode2  = E2;

    @(negedge clk);
    check_eq("reset", obs, 39'h0);
    @(negedge clk);
    reset_l = 1'b1;
    quiet("idle", 5);

    // Ramp burst; amplitude and on_time change mid-burst, affecting burst 2 only.
    enable = 1'b1;
    @(negedge clk);
    model_acc = 0;
    run_burst("b1a", 400, 4, 16, 50, 10);
    amplitude = 6'd20;
    on_time   = 8'd25;
    run_burst("b1b", 400, 4, 16, 50, 40);
    quiet("off", 20000);
    model_acc = 0;
    run_burst("b2", 400, 4, 16, 20, 23);

    // Enable dropped in the second PHASE_A cycle: pulse completes, then idle.
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("drop c%0d", k), obs, exp_out(k, 4, 20));
      if (k == 1) enable = 1'b0;
      @(negedge clk);
    end
    quiet("drop idle", 500);

    // Re-enable restarts the ramp at DAC=1.
    enable = 1'b1;
    @(negedge clk);
    model_acc = 0;
    run_burst("re", 400, 4, 16, 20, 2);

    // Asynchronous reset during PHASE_B.
    for (int k = 0; k < 7; k++) begin
      check_eq($sformatf("pre-rst c%0d", k), obs, exp_out(k, 4, 3));
      if (k != 6) @(negedge clk);
    end
    reset_l = 1'b0;
    #1;
    check_eq("async reset", obs, 39'h0);
    enable = 1'b0;
    repeat (3) @(negedge clk);
    reset_l = 1'b1;
    quiet("post reset", 50);

    // Zero ramp and a period shorter than the pulse: back-to-back at full amplitude.
    freq        = 12'd5;
    ramp_factor = 10'd0;
    amplitude   = 6'd50;
    enable      = 1'b1;
    @(negedge clk);
    model_acc = 0;
    run_burst("fast", 5, 4, 0, 50, 5);
    for (int k = 0; k < 10; k++) begin
      check_eq($sformatf("fast end c%0d", k), obs, exp_out(k, 4, 50));
      if (k == 0) enable = 1'b0;
      @(negedge clk);
    end
    quiet("fast idle", 20);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
